// File: rtl/parity_mon_pkg.sv
// parity_mon_pkg: shared state encodings and default widths for the parity sweep monitor.
package parity_mon_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 5;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/err_addr_fifo.sv
// err_addr_fifo: first-word fall-through FIFO buffering failing {addr, data} entries.
module err_addr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_pop, do_push;
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign count   = cnt_q;
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a push into a full FIFO is still accepted
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q  <= do_pop ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/parity_sweep_monitor.sv
// parity_sweep_monitor: tallies parity pass/fail samples over an address sweep,
// buffers failing entries and reports completion and verdict.
module parity_sweep_monitor
    import parity_mon_pkg::*;
#(
    parameter int ADDR_W     = parity_mon_pkg::ADDR_W,
    parameter int DATA_W     = parity_mon_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = parity_mon_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              match,
    input  logic              rd_en,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              overflow,
    output logic              busy,
    output logic              done,
    output logic              pass
);
    localparam int FW = $clog2(FIFO_DEPTH);
    state_t             state_q;
    logic               busy_q, done_q, ovf_q;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic               accept, push, pop, full, empty;
    logic [FW:0]        fifo_cnt;
    logic [ADDR_W+DATA_W-1:0] head;
    assign accept     = state_q == ST_SWEEP && valid && !start;
    assign push       = accept && !match;
    assign pop        = rd_en && !empty;
    assign pass_cnt_d = pass_cnt_q + CNT_W'(accept && match && pass_cnt_q != '1);
    assign fail_cnt_d = fail_cnt_q + CNT_W'(push && fail_cnt_q != '1);
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if (start) begin
            state_q    <= ST_SWEEP;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ovf_q      <= ovf_q || (push && full && !pop);
            if (accept && addr == '1) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end
    err_addr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (Reset),
        .flush (start),
        .push  (push),
        .pop   (rd_en),
        .din   ({addr, data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );
    assign err_valid = fifo_cnt != '0;
    assign {err_addr, err_data} = head;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = done_q && fail_cnt_q == '0;
endmodule
